// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter_if
// Purpose  : Bundle of every handshake and memory-bus signal between the
//            IF/LS requesters, the shared memory and mem_arbiter.
//            slave  - the arbiter's view (takes requests, drives memory).
//            master - the environment's view (requesters plus memory).
// Ports    : IF  : if_req, if_addr -> if_gnt, if_rvalid, if_rdata
//            LS  : ls_req, ls_we, ls_addr, ls_wdata -> ls_gnt, ls_rvalid,
//                  ls_rdata
//            MEM : mem_address, mem_data_in, mem_write <- mem_data_out
// Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_req;
    logic              ls_we;
    logic [ADDR_W-1:0] ls_addr;
    logic [DATA_W-1:0] ls_wdata;
    logic              ls_gnt;
    logic              ls_rvalid;
    logic [DATA_W-1:0] ls_rdata;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  if_req, if_addr,
        input  ls_req, ls_we, ls_addr, ls_wdata,
        input  mem_data_out,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_address, mem_data_in, mem_write
    );

    modport master (
        output if_req, if_addr,
        output ls_req, ls_we, ls_addr, ls_wdata,
        output mem_data_out,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_address, mem_data_in, mem_write
    );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares one memory port between instruction fetch (IF) and
//            load/store (LS). One request is granted per cycle (grant is
//            combinational); reads return data RD_LATENCY cycles after the
//            grant, writes complete on the grant edge.
// Ports    : clk   - clock, all state on rising edge
//            reset - synchronous, active-high
//            bus   - mem_arbiter_if.slave (requests, responses, memory bus)
// Params   : DATA_W, ADDR_W, RD_LATENCY (1..8; other values unsupported)
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  wire           clk,
    input  wire           reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // The counter holds the number of cycles still to wait after the first
    // WAIT cycle, so loading RD_LATENCY-1 puts the response at grant+RD_LATENCY
    // and lets a latency of 8 fit in 3 bits.
    localparam logic [2:0] c_CNT_LOAD = 3'(RD_LATENCY - 1);

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              owner_ls_q;   // owner of the outstanding read
    logic              last_ls_q;    // 1: LS was granted most recently
    logic [DATA_W-1:0] if_hold_q;
    logic [DATA_W-1:0] ls_hold_q;

    logic w_resp;
    logic w_can_grant;
    logic w_pick_ls;
    logic w_gnt_if;
    logic w_gnt_ls;
    logic w_rd_gnt;

    // Response cycle: last WAIT cycle. It doubles as an idle cycle so a new
    // request can be granted back-to-back.
    assign w_resp      = !reset && (state_q == S_WAIT) && (cnt_q == 3'd0);
    assign w_can_grant = !reset && ((state_q == S_IDLE) || w_resp);

    // Lone requester wins; on conflict the port not granted last wins.
    assign w_pick_ls = bus.ls_req && (!bus.if_req || !last_ls_q);
    assign w_gnt_if  = w_can_grant && bus.if_req && !w_pick_ls;
    assign w_gnt_ls  = w_can_grant && w_pick_ls;
    assign w_rd_gnt  = w_gnt_if || (w_gnt_ls && !bus.ls_we);

    assign bus.if_gnt    = w_gnt_if;
    assign bus.ls_gnt    = w_gnt_ls;
    assign bus.if_rvalid = w_resp && !owner_ls_q;
    assign bus.ls_rvalid = w_resp &&  owner_ls_q;

    always_comb begin
        bus.mem_address = '0;
        bus.mem_data_in = '0;
        bus.mem_write   = 1'b0;
        if (w_gnt_if) begin
            bus.mem_address = bus.if_addr;
        end else if (w_gnt_ls) begin
            bus.mem_address = bus.ls_addr;
            bus.mem_data_in = bus.ls_wdata;
            bus.mem_write   = bus.ls_we;
        end
    end

    // Read data passes straight through in the response cycle and is then
    // served from the per-port hold register.
    always_comb begin
        bus.if_rdata = bus.if_rvalid ? bus.mem_data_out : if_hold_q;
        bus.ls_rdata = bus.ls_rvalid ? bus.mem_data_out : ls_hold_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            owner_ls_q <= 1'b0;
            last_ls_q  <= 1'b1;
            if_hold_q  <= '0;
            ls_hold_q  <= '0;
        end else begin
            if (bus.if_rvalid) begin
                if_hold_q <= bus.mem_data_out;
            end
            if (bus.ls_rvalid) begin
                ls_hold_q <= bus.mem_data_out;
            end
            if (w_gnt_if || w_gnt_ls) begin
                last_ls_q <= w_gnt_ls;
            end

            case (state_q)
                S_IDLE: begin
                    if (w_rd_gnt) begin
                        state_q    <= S_WAIT;
                        cnt_q      <= c_CNT_LOAD;
                        owner_ls_q <= w_gnt_ls;
                    end
                end
                S_WAIT: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else if (w_rd_gnt) begin
                        cnt_q      <= c_CNT_LOAD;
                        owner_ls_q <= w_gnt_ls;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Self-checking bench for mem_arbiter. Two instances run side by
//            side (RD_LATENCY 1 and 3), each with its own memory model,
//            random requesters, reference model and response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int c_NCYC  = 600;
    localparam int c_DRAIN = 12;

    typedef struct {
        int          due;
        bit          ls;
        logic [31:0] data;
    } exp_t;

    logic clk;
    logic init;
    int   cyc;
    int   total;
    int   bad;
    bit   done [2];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input int i);
        if (i == 5) return 32'hDEADBEEF;
        return 32'h5A5A_0000 ^ (32'(i) << 4) ^ 32'(i * 7);
    endfunction

    task automatic chk(input int lat, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL lat%0d %s at cycle %0d: got %h want %h",
                     lat, name, cyc, act, exp);
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        localparam int LAT = (k == 0) ? 1 : 3;

        mem_arbiter_if #(.DATA_W(32), .ADDR_W(16)) bus ();
        logic dut_reset;
        bit   acc_if;
        bit   acc_ls;
        exp_t q[$];

        mem_arbiter #(
            .DATA_W    (32),
            .ADDR_W    (16),
            .RD_LATENCY(LAT)
        ) u_dut (
            .clk  (clk),
            .reset(dut_reset),
            .bus  (bus)
        );

        // Memory: 16 words, read data appears LAT edges after the address.
        logic [31:0] mem  [16];
        logic [31:0] pipe [LAT];
        always @(posedge clk) begin
            if (init) begin
                for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
            end else if (bus.mem_write) begin
                mem[bus.mem_address[3:0]] <= bus.mem_data_in;
            end
            pipe[0] <= mem[bus.mem_address[3:0]];
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.mem_data_out = pipe[LAT-1];

        // Requesters: hold a request until the model says it was accepted.
        initial begin
            bit if_pend;
            bit ls_pend;
            if_pend = 0;
            ls_pend = 0;
            dut_reset    = 1'b1;
            bus.if_req   = 1'b0;
            bus.if_addr  = '0;
            bus.ls_req   = 1'b0;
            bus.ls_we    = 1'b0;
            bus.ls_addr  = '0;
            bus.ls_wdata = '0;
            repeat (3) @(posedge clk);
            for (int n = 0; n < c_NCYC + c_DRAIN; n++) begin
                #1;
                if (acc_if) if_pend = 0;
                if (acc_ls) ls_pend = 0;
                if (n < c_NCYC) begin
                    dut_reset = ($urandom_range(0, 79) == 0);
                    if (!if_pend && $urandom_range(0, 9) < 7) begin
                        if_pend     = 1;
                        bus.if_addr = 16'($urandom_range(0, 15));
                    end
                    if (!ls_pend && $urandom_range(0, 9) < 7) begin
                        ls_pend      = 1;
                        bus.ls_we    = ($urandom_range(0, 2) == 0);
                        bus.ls_addr  = 16'($urandom_range(0, 15));
                        bus.ls_wdata = $urandom;
                    end
                end else begin
                    dut_reset = 1'b0;
                    if_pend   = 0;
                    ls_pend   = 0;
                end
                bus.if_req = if_pend;
                bus.ls_req = ls_pend;
                @(posedge clk);
            end
            @(negedge clk);
            chk(LAT, "outstanding_responses", 64'(q.size()), 64'd0);
            done[k] = 1;
        end

        // Reference model: the memory is busy until the response cycle of
        // the last read; conflicts go to the port not granted last.
        initial begin
            logic [31:0] ref_mem [16];
            int   free_c;
            bit   last_ls;
            bit   gi;
            bit   gl;
            exp_t e;
            logic [15:0] ea;
            logic [31:0] ed;
            bit   ew;
            for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
            free_c  = 0;
            last_ls = 1;
            acc_if  = 0;
            acc_ls  = 0;
            repeat (2) @(posedge clk);
            forever begin
                @(negedge clk);
                gi = 0;
                gl = 0;
                if (dut_reset) begin
                    free_c  = cyc + 1;
                    last_ls = 1;
                end else if (cyc >= free_c) begin
                    if (bus.if_req && bus.ls_req) begin
                        gl = last_ls ? 1'b0 : 1'b1;
                        gi = !gl;
                    end else begin
                        gi = bus.if_req;
                        gl = bus.ls_req;
                    end
                    if (gi || gl) last_ls = gl;
                    if (gi) begin
                        e.due = cyc + LAT; e.ls = 0;
                        e.data = ref_mem[bus.if_addr[3:0]];
                        q.push_back(e);
                        free_c = cyc + LAT;
                    end else if (gl && !bus.ls_we) begin
                        e.due = cyc + LAT; e.ls = 1;
                        e.data = ref_mem[bus.ls_addr[3:0]];
                        q.push_back(e);
                        free_c = cyc + LAT;
                    end else if (gl) begin
                        ref_mem[bus.ls_addr[3:0]] = bus.ls_wdata;
                        free_c = cyc + 1;
                    end
                end
                ea = gi ? bus.if_addr : (gl ? bus.ls_addr : 16'd0);
                ed = gl ? bus.ls_wdata : 32'd0;
                ew = gl && bus.ls_we;
                chk(LAT, "if_gnt", 64'(bus.if_gnt), 64'(gi));
                chk(LAT, "ls_gnt", 64'(bus.ls_gnt), 64'(gl));
                chk(LAT, "mem_address", 64'(bus.mem_address), 64'(ea));
                chk(LAT, "mem_data_in", 64'(bus.mem_data_in), 64'(ed));
                chk(LAT, "mem_write", 64'(bus.mem_write), 64'(ew));
                acc_if = gi;
                acc_ls = gl;
            end
        end

        // Scoreboard monitor: checks every response and the held rdata.
        initial begin
            logic [31:0] h_if;
            logic [31:0] h_ls;
            logic [31:0] ed;
            bit   ev_if;
            bit   ev_ls;
            exp_t e;
            h_if = '0;
            h_ls = '0;
            repeat (2) @(posedge clk);
            forever begin
                @(negedge clk);
                ev_if = 0;
                ev_ls = 0;
                ed    = '0;
                if (!dut_reset && q.size() > 0 && q[0].due == cyc) begin
                    e     = q.pop_front();
                    ev_ls = e.ls;
                    ev_if = !e.ls;
                    ed    = e.data;
                end
                chk(LAT, "if_rvalid", 64'(bus.if_rvalid), 64'(ev_if));
                chk(LAT, "ls_rvalid", 64'(bus.ls_rvalid), 64'(ev_ls));
                chk(LAT, "if_rdata", 64'(bus.if_rdata), 64'(ev_if ? ed : h_if));
                chk(LAT, "ls_rdata", 64'(bus.ls_rdata), 64'(ev_ls ? ed : h_ls));
                if (ev_if) h_if = ed;
                if (ev_ls) h_ls = ed;
                if (dut_reset) begin
                    q.delete();
                    h_if = '0;
                    h_ls = '0;
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        init  = 1'b1;
        repeat (2) @(posedge clk);
        #1 init = 1'b0;
        for (int i = 0; i < 3000 && !(done[0] && done[1]); i++) @(posedge clk);
        if (!(done[0] && done[1])) begin
            total++;
            bad++;
            $display("FAIL timeout: done=%0d%0d want 11", done[0], done[1]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
